// File: rtl/seq_alu.sv
// Registered ALU with start/busy/done handshake and an optional
// iterative shift-add multiplier.
module seq_alu #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] ImmVal,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Carry,
   output logic             Busy,
   output logic             Done
);

   localparam int SW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   typedef enum logic {
      IDLE,
      MUL_RUN
   } state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    mcand_q, mcand_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mplr_q, mplr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   sum, dif, shl;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic [W2-1:0]    acc_nxt;
   logic             is_mul;

   always_comb begin
      sum     = {1'b0, A} + {1'b0, ImmVal};
      dif     = {1'b0, A} - {1'b0, B};
      shamt   = B[SW-1:0];
      shl     = {1'b0, A} << shamt;
      alu_res = '0;
      alu_c   = 1'b0;
      unique case (Op)
         3'b000: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
         end
         3'b001: alu_res = B;
         3'b010: begin
            alu_res = dif[WIDTH-1:0];
            alu_c   = ~dif[WIDTH];
         end
         3'b011: alu_res = A & B;
         3'b100: alu_res = A | B;
         3'b101: alu_res = A ^ B;
         3'b110: begin
            alu_res = shl[WIDTH-1:0];
            alu_c   = shl[WIDTH];
         end
         3'b111: begin
            alu_res = '0;
            alu_c   = 1'b0;
         end
         default: ;
      endcase
   end

   assign is_mul  = MUL_EN && (Op == 3'b111);
   assign acc_nxt = acc_q + (mplr_q[0] ? mcand_q : '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mplr_d  = mplr_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start && is_mul) begin
               mcand_d = {{WIDTH{1'b0}}, A};
               mplr_d  = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL_RUN;
            end else if (Start) begin
               res_d   = alu_res;
               zero_d  = (alu_res == '0);
               carry_d = alu_c;
               done_d  = 1'b1;
            end
         end
         MUL_RUN: begin
            acc_d   = acc_nxt;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            // last partial product lands on this edge
            if (cnt_q == SW'(WIDTH - 1)) begin
               res_d   = acc_nxt[WIDTH-1:0];
               zero_d  = (acc_nxt[WIDTH-1:0] == '0);
               carry_d = |acc_nxt[W2-1:WIDTH];
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
         mplr_q  <= '0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mplr_q  <= mplr_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         done_q  <= done_d;
      end
   end

   assign Result = res_q;
   assign Zero   = zero_q;
   assign Carry  = carry_q;
   assign Done   = done_q;
   assign Busy   = (state_q == MUL_RUN);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: 8-bit, 16-bit and multiplier-less
// instances driven in turn against a behavioural model.
module tb_seq_alu;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        s0, s1, s2;
   logic [2:0]  op0, op1;
   logic [7:0]  a0, b0, i0;
   logic [15:0] a1, b1, i1;
   logic [7:0]  r0, r2;
   logic [15:0] r1;
   logic        z0, c0, bz0, d0;
   logic        z1, c1, bz1, d1;
   logic        z2, c2, bz2, d2;

   exp_t q0[$], q1[$], q2[$];
   int checks = 0;
   int failures = 0;

   seq_alu #(.WIDTH(8), .MUL_EN(1'b1)) u_d0 (
      .clk(clk), .rst_n(rst_n), .Start(s0), .Op(op0),
      .A(a0), .B(b0), .ImmVal(i0), .Result(r0),
      .Zero(z0), .Carry(c0), .Busy(bz0), .Done(d0));

   seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .Start(s1), .Op(op1),
      .A(a1), .B(b1), .ImmVal(i1), .Result(r1),
      .Zero(z1), .Carry(c1), .Busy(bz1), .Done(d1));

   seq_alu #(.WIDTH(8), .MUL_EN(1'b0)) u_d2 (
      .clk(clk), .rst_n(rst_n), .Start(s2), .Op(op0),
      .A(a0), .B(b0), .ImmVal(i0), .Result(r2),
      .Zero(z2), .Carry(c2), .Busy(bz2), .Done(d2));

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input bit men);
      longint unsigned m, s, p, sh;
      exp_t e;
      m = (64'd1 << w) - 1;
      e.c = 1'b0;
      s = 0;
      case (op)
         3'd0: begin
            s = longint'(a) + longint'(imm);
            e.c = s[w];
         end
         3'd1: s = longint'(b);
         3'd2: begin
            s = longint'(a) - longint'(b);
            e.c = (a >= b);
         end
         3'd3: s = longint'(a & b);
         3'd4: s = longint'(a | b);
         3'd5: s = longint'(a ^ b);
         3'd6: begin
            sh = longint'(b) % longint'(w);
            s = longint'(a) << sh;
            if (sh != 0) e.c = s[w];
         end
         default: begin
            if (men) begin
               p = longint'(a) * longint'(b);
               s = p;
               e.c = ((p >> w) != 0);
            end
         end
      endcase
      e.res = 32'(s & m);
      e.z = (e.res == 0);
      return e;
   endfunction

   task automatic issue(input int which, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input bit push);
      if (which == 1) begin
         op1 = op; a1 = a[15:0]; b1 = b[15:0]; i1 = imm[15:0]; s1 = 1'b1;
         if (push) q1.push_back(model(16, op, a, b, imm, 1'b1));
      end else begin
         op0 = op; a0 = a[7:0]; b0 = b[7:0]; i0 = imm[7:0];
         if (which == 0) begin
            s0 = 1'b1;
            if (push) q0.push_back(model(8, op, a, b, imm, 1'b1));
         end else begin
            s2 = 1'b1;
            if (push) q2.push_back(model(8, op, a, b, imm, 1'b0));
         end
      end
      @(posedge clk);
      #1;
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
   endtask

   task automatic busy_len(input int which, output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((which == 1) ? bz1 : bz0) n++;
         else break;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (d0) begin
         if (q0.size() == 0) chk("d0_spurious", 1, 0);
         else begin
            e = q0.pop_front();
            chk("r0", r0, e.res);
            chk("z0", z0, e.z);
            chk("c0", c0, e.c);
         end
      end
      if (d1) begin
         if (q1.size() == 0) chk("d1_spurious", 1, 0);
         else begin
            e = q1.pop_front();
            chk("r1", r1, e.res);
            chk("z1", z1, e.z);
            chk("c1", c1, e.c);
         end
      end
      if (d2) begin
         if (q2.size() == 0) chk("d2_spurious", 1, 0);
         else begin
            e = q2.pop_front();
            chk("r2", r2, e.res);
            chk("z2", z2, e.z);
            chk("c2", c2, e.c);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      s0 = 1'b0; s1 = 1'b0; s2 = 1'b0;
      op0 = '0; a0 = '0; b0 = '0; i0 = '0;
      op1 = '0; a1 = '0; b1 = '0; i1 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_res", r0, 0);
         chk("rst_zero", z0, 1);
         chk("rst_carry", c0, 0);
         chk("rst_busy", bz0, 0);
         chk("rst_done", d0, 0);
      end
      @(posedge clk);
      #1;

      issue(0, 3'd0, 8'hF0, 8'h00, 8'h20, 1);
      chk("addi_done", d0, 1);
      issue(0, 3'd1, 8'h00, 8'h00, 8'h00, 1);
      issue(0, 3'd2, 8'h05, 8'h07, 8'h00, 1);
      issue(0, 3'd6, 8'h81, 8'h01, 8'h00, 1);
      issue(0, 3'd3, 8'hC3, 8'h5A, 8'h00, 1);
      issue(0, 3'd4, 8'h0F, 8'h30, 8'h00, 1);
      issue(0, 3'd6, 8'h81, 8'h00, 8'h00, 1);

      issue(0, 3'd7, 8'd13, 8'd11, 8'h00, 1);
      busy_len(0, n);
      chk("mul_busy8", n, 8);
      @(posedge clk);
      #1;
      issue(0, 3'd7, 8'h20, 8'h10, 8'h00, 1);
      busy_len(0, n);
      chk("mul_ovf_busy8", n, 8);
      @(posedge clk);
      #1;

      issue(0, 3'd7, 8'd13, 8'd11, 8'h00, 1);
      issue(0, 3'd0, 8'h77, 8'h66, 8'h55, 0);
      repeat (7) @(posedge clk);
      #1;
      chk("done_b2b", d0, 1);
      chk("busy_b2b", bz0, 0);
      issue(0, 3'd5, 8'hAA, 8'hFF, 8'h00, 1);
      @(negedge clk);
      chk("xor_res", r0, 8'h55);

      @(posedge clk);
      #1;
      issue(0, 3'd7, 8'd13, 8'd11, 8'h00, 0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_res", r0, 0);
      chk("abort_zero", z0, 1);
      chk("abort_carry", c0, 0);
      chk("abort_busy", bz0, 0);
      chk("abort_done", d0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_idle", bz0, 0);

      issue(1, 3'd7, 300, 300, 0, 1);
      busy_len(1, n);
      chk("mul16_busy", n, 16);
      @(posedge clk);
      #1;
      issue(1, 3'd0, 16'hFFFF, 0, 1, 1);
      issue(1, 3'd6, 16'h8001, 15, 0, 1);

      issue(2, 3'd7, 8'd13, 8'd11, 8'h00, 1);
      chk("nomul_done", d2, 1);
      chk("nomul_busy", bz2, 0);
      @(posedge clk);
      #1;
      chk("nomul_pulse", d2, 0);

      repeat (4) @(posedge clk);
      chk("q0_empty", q0.size(), 0);
      chk("q1_empty", q1.size(), 0);
      chk("q2_empty", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
